// File: rtl/ins_fetch_if.sv
// Fetch-unit bus: program-memory handshake plus the decoder-facing opcode/operand strobe.
// The master modport is the fetch sequencer; the slave side is memory and decoder.
interface ins_fetch_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [3:0]        ins;
    logic [3:0]        imm;
    logic              ins_valid;
    logic              jump;
    logic              halted;

    modport master (
        output mem_addr, mem_req, ins, imm, ins_valid, halted,
        input  mem_ack, mem_data, jump
    );

    modport slave (
        input  mem_addr, mem_req, ins, imm, ins_valid, halted,
        output mem_ack, mem_data, jump
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch sequencer: owns the PC, fetches 8-bit words over req/ack,
// strobes opcode/immediate to the decoder, then advances or jumps the PC.
module ins_fetch #(
    parameter int         ADDR_W  = 4,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    ins_fetch_if.master  bus
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_req_q,   mem_req_d;
    logic [3:0]        ins_q,       ins_d;
    logic [3:0]        imm_q,       imm_d;
    logic              ins_valid_q, ins_valid_d;
    logic              halted_q,    halted_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        ins_d       = ins_q;
        imm_d       = imm_q;
        ins_valid_d = 1'b0;
        halted_d    = halted_q;

        case (state_q)
            ST_FETCH: begin
                // An ack only counts while our own request is up; stale acks fall through.
                if (mem_req_q && bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (bus.mem_data[7:4] != HALT_OP) begin
                        ins_d       = bus.mem_data[7:4];
                        imm_d       = bus.mem_data[3:0];
                        ins_valid_d = 1'b1;
                        state_d     = ST_EXEC;
                    end else begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end

            ST_EXEC: begin
                // Re-arm the request here so zero-wait memory sustains one word per 2 cycles.
                if (bus.jump) begin
                    pc_d = ADDR_W'(imm_q);
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                mem_addr_d = pc_d;
                mem_req_d  = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_HALT: begin
                mem_req_d = 1'b0;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            ins_q       <= 4'd0;
            imm_q       <= 4'd0;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            ins_q       <= ins_d;
            imm_q       <= imm_d;
            ins_valid_q <= ins_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.ins       = ins_q;
    assign bus.imm       = imm_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: a ROM/decoder model answers the bus, directed
// programs push expected strobes, and a monitor pops and compares each ins_valid.
module tb_ins_fetch;

    typedef struct {
        logic [3:0] ins;
        logic [3:0] imm;
        logic [3:0] addr;
        int         gap;
    } exp_t;

    logic clk;
    logic rst;
    ins_fetch_if #(.ADDR_W(4)) bus ();

    ins_fetch #(.ADDR_W(4), .HALT_OP(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   cyc       = 0;
    exp_t exp_q[$];

    logic [7:0] rom [16];
    int         wait_n        = 0;
    int         req_cnt       = 0;
    bit         stale_ack     = 1'b0;
    bit         toggle_mode   = 1'b0;
    bit         jump_op_en    = 1'b0;
    logic [3:0] jump_op       = 4'h0;
    bit         jump_outside  = 1'b0;
    logic [3:0] last_ack_addr = 4'h0;
    int         last_valid_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory answers after wait_n request cycles; the decoder model raises jump combinationally.
    always @(negedge clk) begin
        if (toggle_mode) begin
            bus.mem_ack  = ~bus.mem_ack;
            bus.jump     = ~bus.jump;
            bus.mem_data = rom[bus.mem_addr];
        end else begin
            if (bus.mem_req) begin
                if (req_cnt == wait_n) begin
                    bus.mem_ack   = 1'b1;
                    last_ack_addr = bus.mem_addr;
                end else begin
                    bus.mem_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                req_cnt     = 0;
                bus.mem_ack = stale_ack;
            end
            bus.mem_data = rom[bus.mem_addr];
            bus.jump = (jump_op_en && bus.ins_valid && bus.ins == jump_op) ||
                       (jump_outside && !bus.ins_valid);
        end
    end

    always @(negedge clk) begin
        if (bus.ins_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", {bus.ins, bus.imm}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("strobe_ins_imm", {bus.ins, bus.imm}, {e.ins, e.imm});
                checkOutput("strobe_fetch_addr", last_ack_addr, e.addr);
                if (e.gap != 0) checkOutput("strobe_gap", cyc - last_valid_cyc, e.gap);
            end
            last_valid_cyc = cyc;
        end
    end

    task automatic applyStimulus(input int addr, input logic [7:0] word);
        rom[addr] = word;
    endtask

    task automatic expectStrobe(input logic [3:0] ins, input logic [3:0] imm, input logic [3:0] addr, input int gap);
        exp_t e;
        e.ins = ins; e.imm = imm; e.addr = addr; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
    endtask

    task automatic checkReset(input string name);
        checkOutput(name, {bus.halted, bus.mem_req, bus.ins_valid, bus.mem_addr, bus.ins, bus.imm}, 32'd0);
    endtask

    task automatic applyReset(input string name);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkReset(name);
        rst = 1'b0;
    endtask

    task automatic waitStrobe(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ins_valid && n < 40);
        if (!bus.ins_valid) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitHalted(input string name);
        int n = 0;
        while (!bus.halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_halted"}, bus.halted, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clearRom();

        // Zero-wait linear run ending in a halt at address 2.
        applyStimulus(0, 8'h05);
        applyStimulus(1, 8'h13);
        applyStimulus(2, 8'hF0);
        expectStrobe(4'h0, 4'h5, 4'd0, 0);
        expectStrobe(4'h1, 4'h3, 4'd1, 2);
        applyReset("t1_reset");
        @(negedge clk);
        checkOutput("t1_first_req", {bus.mem_req, bus.mem_addr}, {1'b1, 4'd0});
        waitHalted("t1");
        @(negedge clk);
        checkOutput("t1_halt_bus", {bus.mem_req, bus.ins_valid, bus.mem_addr}, {1'b0, 1'b0, 4'd2});
        checkOutput("t1_halt_keeps_ins", {bus.ins, bus.imm}, 8'h13);
        checkOutput("t1_queue_empty", exp_q.size(), 32'd0);

        // Three wait states: request held four cycles, strobes five apart.
        clearRom();
        wait_n = 3;
        applyStimulus(0, 8'h21);
        applyStimulus(1, 8'h34);
        expectStrobe(4'h2, 4'h1, 4'd0, 0);
        expectStrobe(4'h3, 4'h4, 4'd1, 5);
        applyReset("t2_reset");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t2_req_stable", {bus.mem_req, bus.mem_addr, bus.ins_valid}, {1'b1, 4'd0, 1'b0});
        end
        @(negedge clk);
        checkOutput("t2_valid_after_ack", bus.ins_valid, 32'd1);
        waitHalted("t2");
        checkOutput("t2_halt_addr", bus.mem_addr, 32'd2);

        // Jump taken in EXEC redirects the next fetch to the immediate.
        clearRom();
        wait_n = 0;
        jump_op_en = 1'b1;
        jump_op = 4'h4;
        applyStimulus(0, 8'h47);
        applyStimulus(1, 8'h11);
        expectStrobe(4'h4, 4'h7, 4'd0, 0);
        applyReset("t3_reset");
        waitStrobe("t3_strobe");
        @(negedge clk);
        checkOutput("t3_jump_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 4'd7});
        waitHalted("t3");
        checkOutput("t3_halt_addr", bus.mem_addr, 32'd7);

        // Jump held high everywhere except EXEC must not disturb the PC.
        clearRom();
        jump_op_en = 1'b0;
        jump_outside = 1'b1;
        applyStimulus(0, 8'h09);
        applyStimulus(1, 8'h1C);
        expectStrobe(4'h0, 4'h9, 4'd0, 0);
        expectStrobe(4'h1, 4'hC, 4'd1, 2);
        applyReset("t3b_reset");
        waitHalted("t3b");
        checkOutput("t3b_halt_addr", bus.mem_addr, 32'd2);

        // Jump to 15, then a plain EXEC there wraps the PC to 0.
        clearRom();
        jump_outside = 1'b0;
        jump_op_en = 1'b1;
        jump_op = 4'h8;
        applyStimulus(0, 8'h8F);
        applyStimulus(15, 8'h2A);
        expectStrobe(4'h8, 4'hF, 4'd0, 0);
        expectStrobe(4'h2, 4'hA, 4'd15, 2);
        applyReset("t4_reset");
        waitStrobe("t4_strobe1");
        applyStimulus(0, 8'hF0);
        waitStrobe("t4_strobe2");
        @(negedge clk);
        checkOutput("t4_wrap_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 4'd0});
        waitHalted("t4");
        checkOutput("t4_halt_addr", bus.mem_addr, 32'd0);

        // Reset during a pending fetch, then a stale ack while the request is low.
        clearRom();
        jump_op_en = 1'b0;
        applyStimulus(0, 8'h31);
        applyStimulus(1, 8'h62);
        expectStrobe(4'h3, 4'h1, 4'd0, 0);
        applyReset("t5_reset");
        waitStrobe("t5_strobe");
        wait_n = 4;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_pending", {bus.mem_req, bus.mem_addr, bus.ins, bus.imm}, {1'b1, 4'd1, 4'h3, 4'h1});
        rst = 1'b1;
        wait_n = 0;
        stale_ack = 1'b1;
        applyStimulus(1, 8'hF0);
        expectStrobe(4'h3, 4'h1, 4'd0, 0);
        @(negedge clk);
        checkReset("t5_mid_reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_stale_ignored", {bus.mem_req, bus.mem_addr, bus.ins_valid}, {1'b1, 4'd0, 1'b0});
        stale_ack = 1'b0;
        waitHalted("t5");
        checkOutput("t5_halt_addr", bus.mem_addr, 32'd1);

        // Halt must ignore ack/jump activity until reset.
        toggle_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("t6_halt_hold",
                        {bus.halted, bus.mem_req, bus.ins_valid, bus.mem_addr, bus.ins, bus.imm},
                        {1'b1, 1'b0, 1'b0, 4'd1, 4'h3, 4'h1});
        end
        toggle_mode = 1'b0;
        clearRom();
        applyStimulus(0, 8'h7E);
        expectStrobe(4'h7, 4'hE, 4'd0, 0);
        applyReset("t6_reset");
        @(negedge clk);
        checkOutput("t6_restart", {bus.mem_req, bus.mem_addr}, {1'b1, 4'd0});
        waitHalted("t6");
        checkOutput("t6_halt_addr", bus.mem_addr, 32'd1);
        checkOutput("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch sequencer for the 4-bit CPU: drives the opcode side of the instruction decoder. It holds the program counter and requests 8-bit instruction words from program memory over a req/ack handshake. It presents each word to the decoder and datapath as `ins` (opcode) and `imm` (operand) with a one-cycle valid strobe, then advances or jumps the PC using the decoder's `jump` output.

## Interface
Parameters:
- `ADDR_W`, 4, program-counter and memory-address width.
- `HALT_OP`, 4'hF, opcode that stops fetching.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mem_addr`  out  ADDR_W  program-memory address, equals PC while `mem_req`=1.
- `mem_req`  out  1  fetch request, registered.
- `mem_ack`  in  1  memory response; `mem_data` is valid in the same cycle.
- `mem_data`  in  8  instruction word; [7:4] opcode, [3:0] immediate.
- `ins`  out  4  opcode to the decoder, registered.
- `imm`  out  4  immediate operand to the datapath, registered.
- `ins_valid`  out  1  one-cycle strobe; `ins`/`imm` are live for execution.
- `jump`  in  1  decoder jump request, sampled only in EXEC.
- `halted`  out  1  high once `HALT_OP` has been fetched.

## Operation
- Reset, checked in any state and overriding everything:
  - PC=0, state FETCH.
  - `mem_req`=0, `mem_addr`=0, `ins`=0, `imm`=0, `ins_valid`=0, `halted`=0.
- States are FETCH, EXEC and HALT.
- FETCH:
  - `mem_req`=1, `mem_addr`=PC; both stay stable until ack.
  - When `mem_ack`=1 and `mem_req`=1: capture `mem_data`.
  - If opcode ≠ `HALT_OP`: load `ins`/`imm` and go to EXEC.
  - If opcode = `HALT_OP`: go to HALT. `ins`/`imm` are not updated and `ins_valid` stays 0.
  - `mem_req` drops in the cycle after ack.
- EXEC:
  - `ins_valid`=1 for exactly this cycle.
  - `jump`=1: PC ← zero-extended `imm`. Otherwise PC ← PC+1, wrapping modulo 2^ADDR_W (max → 0).
  - Always returns to FETCH.
- HALT:
  - `halted`=1, `mem_req`=0.
  - PC holds the halt instruction's address; `mem_addr` holds its last value.
  - Only `rst` exits HALT.
- `ins`/`imm` hold their values between strobes. Datapath loads must be qualified by `ins_valid`.
- `mem_ack` while `mem_req`=0 is ignored, including a stale ack after reset.
- `jump` outside EXEC is ignored.

## Timing
- Earliest `mem_req`=1 is the first cycle after `rst` deasserts.
- Ack may arrive in the first request cycle. Zero-wait throughput is one instruction per 2 cycles (FETCH, EXEC).
- N wait cycles before ack give 2+N cycles per instruction.
- `ins_valid` rises the cycle after the ack cycle.
- The next `mem_addr` (new PC) appears the cycle after `ins_valid`.
- The decoder is combinational, so `jump` must be valid in the same cycle as `ins_valid`.
- Reset mid-fetch: `mem_req` is 0 in the cycle after `rst` is sampled. The memory must drop `mem_ack` when `mem_req` drops.

## Test plan
- **Zero-wait linear run.** ROM[0]=0x05, ROM[1]=0x13, ROM[2]=0xF0, ack in the same cycle as req, `jump`=0.
  - `ins_valid` pulses twice, 2 cycles apart, with `ins`/`imm` = 0/5 then 1/3.
  - Then `halted`=1, `mem_addr`=2, `mem_req`=0.
- **Wait states.** Ack 3 cycles after `mem_req` rises.
  - `mem_req` stays high and `mem_addr` stays stable for 4 cycles.
  - `ins_valid` strobes are 5 cycles apart.
- **Jump.** ROM[0]=0x47, `jump`=1 during EXEC.
  - The next fetch has `mem_addr`=7.
  - With `jump`=1 outside EXEC, the PC is unaffected.
- **PC wrap.** ROM[15]=0x2A, `jump`=0.
  - After the EXEC of address 15, the next `mem_addr`=0.
- **Reset mid-wait.** Assert `rst` for 1 cycle while `mem_req`=1 and ack is pending.
  - Next cycle: all outputs are at reset values.
  - A stale `mem_ack` arriving while `mem_req`=0 is ignored.
  - Fetching restarts at address 0.
- **Halt hold.** After HALT, toggle `mem_ack`/`jump` for 20 cycles.
  - `mem_req`, `ins_valid`, PC and `ins` stay unchanged.
  - Then `rst` restarts fetching from address 0.
